// File: rtl/sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sar_seq_ctrl
//
// Purpose:
//   Sequencer for a successive-approximation ADC. It runs a programmable
//   sample phase, then a binary search of N comparator decisions, then
//   publishes the result with a one-cycle DONE pulse. In continuous mode, or
//   if START is held at completion, the next conversion begins with no idle
//   cycle in between. Every output comes straight from a register.
//
// Parameters:
//   N      conversion resolution in bits (2..12)
//   TSAMP  sample phase length in clock cycles (1..15)
//
// Ports:
//   CK      in   clock; all state changes on its rising edge
//   R       in   asynchronous active-high reset
//   START   in   conversion request, only acted on in IDLE and DONE
//   CONT    in   continuous-mode enable, only acted on in DONE
//   CMP     in   comparator decision (1: Vin >= DAC), only used in CONV
//   SAMP    out  sampling switch enable
//   CMP_EN  out  comparator strobe, high during the bit-decision cycles
//   DAC     out  [N-1:0] capacitor DAC trial code
//   DOUT    out  [N-1:0] last result, held until the next DONE
//   BUSY    out  high whenever the sequencer is not idle
//   DONE    out  one-cycle result-valid pulse
// -----------------------------------------------------------------------------
module sar_seq_ctrl #(
  parameter int N     = 8,
  parameter int TSAMP = 2
) (
  input  logic         CK,
  input  logic         R,
  input  logic         START,
  input  logic         CONT,
  input  logic         CMP,
  output logic         SAMP,
  output logic         CMP_EN,
  output logic [N-1:0] DAC,
  output logic [N-1:0] DOUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int              KW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]      CNT_LOAD = 4'(TSAMP - 1);
  localparam logic [KW-1:0]   K_TOP    = KW'(N - 1);
  localparam logic [N-1:0]    DAC_MSB  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONV,
    ST_DONE
  } state_t;

  state_t         state_reg,  state_next;
  logic [3:0]     cnt_reg,    cnt_next;
  logic [KW-1:0]  k_reg,      k_next;
  logic [N-1:0]   dac_reg,    dac_next;
  logic [N-1:0]   dout_reg,   dout_next;
  logic           samp_reg,   samp_next;
  logic           cmp_en_reg, cmp_en_next;
  logic           busy_reg,   busy_next;
  logic           done_reg,   done_next;

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      k_reg      <= '0;
      dac_reg    <= '0;
      dout_reg   <= '0;
      samp_reg   <= 1'b0;
      cmp_en_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      k_reg      <= k_next;
      dac_reg    <= dac_next;
      dout_reg   <= dout_next;
      samp_reg   <= samp_next;
      cmp_en_reg <= cmp_en_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    k_next      = k_reg;
    dac_next    = dac_reg;
    dout_next   = dout_reg;
    samp_next   = samp_reg;
    cmp_en_next = cmp_en_reg;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          state_next = ST_SAMPLE;
          cnt_next   = CNT_LOAD;
          dac_next   = '0;
          samp_next  = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (cnt_reg == 4'd0) begin
          state_next  = ST_CONV;
          samp_next   = 1'b0;
          cmp_en_next = 1'b1;
          dac_next    = DAC_MSB;
          k_next      = K_TOP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      ST_CONV: begin
        if (k_reg != '0) begin
          // Keep or drop the current trial bit, then try the next lower one.
          dac_next[k_reg]        = CMP;
          dac_next[k_reg - 1'b1] = 1'b1;
          k_next                 = k_reg - 1'b1;
        end else begin
          // Last decision goes straight into the result; DAC is released.
          dout_next   = {dac_reg[N-1:1], CMP};
          state_next  = ST_DONE;
          done_next   = 1'b1;
          cmp_en_next = 1'b0;
          dac_next    = '0;
        end
      end

      ST_DONE: begin
        if (CONT || START) begin
          state_next = ST_SAMPLE;
          cnt_next   = CNT_LOAD;
          dac_next   = '0;
          samp_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next  = ST_IDLE;
        samp_next   = 1'b0;
        cmp_en_next = 1'b0;
        dac_next    = '0;
      end
    endcase

    // Registered copy of "not idle" so BUSY tracks the state exactly.
    busy_next = (state_next != ST_IDLE);
  end

  assign SAMP   = samp_reg;
  assign CMP_EN = cmp_en_reg;
  assign DAC    = dac_reg;
  assign DOUT   = dout_reg;
  assign BUSY   = busy_reg;
  assign DONE   = done_reg;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_seq_ctrl
//
// Purpose:
//   Self-checking bench for sar_seq_ctrl. The comparator is modelled as an
//   ideal Vin >= DAC decision (or tied high/low); outside conversion cycles
//   CMP carries random noise. Expected behaviour per conversion is derived
//   from cycle count since the START edge and from the binary-search rule
//   (trial code = bits of Vin above the trial bit, trial bit set, rest zero).
// -----------------------------------------------------------------------------
module tb_sar_seq_ctrl;

  localparam int N     = 8;
  localparam int TSAMP = 2;
  localparam int L     = TSAMP + N + 1;  // edge number after which DONE is high

  logic         CK    = 1'b0;
  logic         R     = 1'b1;
  logic         START = 1'b0;
  logic         CONT  = 1'b0;
  logic         CMP;
  logic         SAMP;
  logic         CMP_EN;
  logic [N-1:0] DAC;
  logic [N-1:0] DOUT;
  logic         BUSY;
  logic         DONE;

  int           checks   = 0;
  int           errors   = 0;
  logic [N-1:0] vin      = '0;
  logic [N-1:0] exp_dout = '0;
  int           cmp_mode = 0;   // 0: ideal comparator, 1: tied high, 2: tied low
  logic         noise    = 1'b0;
  int           busy_cnt = 0;

  sar_seq_ctrl #(.N(N), .TSAMP(TSAMP)) dut (
    .CK     (CK),
    .R      (R),
    .START  (START),
    .CONT   (CONT),
    .CMP    (CMP),
    .SAMP   (SAMP),
    .CMP_EN (CMP_EN),
    .DAC    (DAC),
    .DOUT   (DOUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CK = ~CK;

  assign CMP = (cmp_mode == 1) ? 1'b1 :
               (cmp_mode == 2) ? 1'b0 :
               (CMP_EN ? (vin >= DAC) : noise);

  initial begin
    forever begin
      @(negedge CK);
      noise = 1'($urandom);
    end
  end

  // Invariant monitor: strobe/sample exclusivity and single-cycle DONE.
  initial begin
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge CK);
      checks++;
      if (SAMP && CMP_EN) begin
        errors++;
        $display("FAIL samp_cmp_en_excl: samp=%b cmp_en=%b, required not both 1", SAMP, CMP_EN);
      end
      checks++;
      if (prev_done && DONE) begin
        errors++;
        $display("FAIL done_single: done high two cycles in a row, required one-cycle pulse");
      end
      prev_done = DONE;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // One conversion. Entered just after a rising edge. chained=1 means the FSM
  // is in its DONE cycle and will restart on its own (CONT held high).
  // poke_at>0 raises START for one cycle after that edge number.
  // cont_mid>=0 drives CONT to that value after edge 2.
  // tail=1 checks the FSM returns to idle after the DONE cycle.
  task automatic run_conv(input logic [N-1:0] v, input bit chained,
                          input int poke_at, input int cont_mid, input bit tail);
    int           iv;
    int           bi;
    logic [N-1:0] e_dac;
    logic         e_samp, e_cmpen, e_done;
    iv  = int'(v);
    vin = v;
    if (!chained) START = 1'b1;
    busy_cnt = 0;
    for (int e = 1; e <= L; e++) begin
      @(posedge CK); #1;
      START = (e == poke_at);
      if (e == 2 && cont_mid >= 0) CONT = (cont_mid != 0);
      if (e <= TSAMP) begin
        e_samp = 1'b1; e_cmpen = 1'b0; e_done = 1'b0; e_dac = '0;
      end else if (e <= TSAMP + N) begin
        bi      = N - 1 - (e - TSAMP - 1);
        e_dac   = N'(((iv >> (bi + 1)) << (bi + 1)) | (1 << bi));
        e_samp  = 1'b0; e_cmpen = 1'b1; e_done = 1'b0;
      end else begin
        e_samp = 1'b0; e_cmpen = 1'b0; e_done = 1'b1; e_dac = '0;
        exp_dout = v;
      end
      if (BUSY) busy_cnt++;
      checks++;
      if ({SAMP, CMP_EN, BUSY, DONE, DAC, DOUT} !== {e_samp, e_cmpen, 1'b1, e_done, e_dac, exp_dout}) begin
        errors++;
        $display("FAIL conv_cycle e=%0d vin=%h: samp,cmp_en,busy,done=%b%b%b%b dac=%h dout=%h, required %b%b1%b dac=%h dout=%h",
                 e, v, SAMP, CMP_EN, BUSY, DONE, DAC, DOUT, e_samp, e_cmpen, e_done, e_dac, exp_dout);
      end
    end
    if (tail) begin
      @(posedge CK); #1;
      if (BUSY) busy_cnt++;
      checks++;
      if ({SAMP, CMP_EN, BUSY, DONE, DAC, DOUT} !== {4'b0000, {N{1'b0}}, exp_dout}) begin
        errors++;
        $display("FAIL conv_idle vin=%h: samp,cmp_en,busy,done=%b%b%b%b dac=%h dout=%h, required 0000 dac=00 dout=%h",
                 v, SAMP, CMP_EN, BUSY, DONE, DAC, DOUT, exp_dout);
      end
    end
    $display("conv vin=%h chained=%0d poke=%0d dout=%h busy_cycles=%0d", v, chained, poke_at, DOUT, busy_cnt);
  endtask

  task automatic test_reset();
    R = 1'b1; START = 1'b1; CONT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CK); #1;
      checks++;
      if ({SAMP, CMP_EN, BUSY, DONE, DAC, DOUT} !== {4'b0000, {(2*N){1'b0}}}) begin
        errors++;
        $display("FAIL reset_state: samp,cmp_en,busy,done=%b%b%b%b dac=%h dout=%h, required all zero",
                 SAMP, CMP_EN, BUSY, DONE, DAC, DOUT);
      end
    end
    START = 1'b0; R = 1'b0;
    @(posedge CK); #1;
    checks++;
    if (BUSY !== 1'b0 || SAMP !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b samp=%b, required 0 0", BUSY, SAMP);
    end
    $display("reset done");
  endtask

  task automatic test_nominal();
    run_conv(8'hA5, 1'b0, 0, -1, 1'b1);
    checks++;
    if (DOUT !== 8'hA5) begin
      errors++;
      $display("FAIL nominal_dout: dout=%h, required a5", DOUT);
    end
  endtask

  task automatic test_extremes();
    cmp_mode = 1;
    run_conv(8'hFF, 1'b0, 0, -1, 1'b1);
    checks++;
    if (DOUT !== 8'hFF || busy_cnt != 11) begin
      errors++;
      $display("FAIL extreme_high: dout=%h busy_cycles=%0d, required ff 11", DOUT, busy_cnt);
    end
    cmp_mode = 2;
    run_conv(8'h00, 1'b0, 0, -1, 1'b1);
    checks++;
    if (DOUT !== 8'h00 || busy_cnt != 11) begin
      errors++;
      $display("FAIL extreme_low: dout=%h busy_cycles=%0d, required 00 11", DOUT, busy_cnt);
    end
    cmp_mode = 0;
  endtask

  task automatic test_busy_start();
    run_conv(8'($urandom), 1'b0, TSAMP + 3, -1, 1'b1);   // during CONV
    run_conv(8'($urandom), 1'b0, 1, -1, 1'b1);           // during SAMPLE
    run_conv(8'($urandom), 1'b0, L - 1, -1, 1'b1);       // on the last decision edge
  endtask

  task automatic test_back_to_back();
    CONT = 1'b1;
    run_conv(8'h10, 1'b0, 0, -1, 1'b0);
    run_conv(8'h3C, 1'b1, 0, -1, 1'b0);
    run_conv(8'($urandom), 1'b1, 0, 0, 1'b1);  // CONT dropped mid-conversion
    checks++;
    if (CONT !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: busy=%b, required 0 after CONT cleared", BUSY);
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [N-1:0] v;
    v = 8'($urandom_range(1, 255));
    vin = v;
    START = 1'b1;
    for (int e = 1; e <= TSAMP + 4; e++) begin  // leaves bit index at 4
      @(posedge CK); #1;
      START = 1'b0;
    end
    #2;
    R = 1'b1;
    #1;
    exp_dout = '0;
    checks++;
    if ({SAMP, CMP_EN, BUSY, DONE, DAC, DOUT} !== {4'b0000, {(2*N){1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid_conv: samp,cmp_en,busy,done=%b%b%b%b dac=%h dout=%h, required all zero",
               SAMP, CMP_EN, BUSY, DONE, DAC, DOUT);
    end
    @(posedge CK); #1;
    R = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      @(posedge CK); #1;
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || DOUT !== '0) begin
        errors++;
        $display("FAIL reset_no_done: done=%b busy=%b dout=%h, required 0 0 00", DONE, BUSY, DOUT);
      end
    end
    $display("reset mid-conversion vin=%h aborted", v);
    run_conv(v, 1'b0, 0, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge CK); #1;
        checks++;
        if (BUSY !== 1'b0 || DOUT !== exp_dout) begin
          errors++;
          $display("FAIL idle_hold: busy=%b dout=%h, required 0 %h", BUSY, DOUT, exp_dout);
        end
      end
      run_conv(8'($urandom), 1'b0, $urandom_range(0, L - 1), -1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_conv();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
